// File: rtl/vxe_biu_arb2_pkg.sv
// vxe_biu_arb2_pkg: shared constants for the two-client BIU arbiter.
// Client index width sets the tag prefixed to every BIU-side CID.
package vxe_biu_arb2_pkg;
    localparam int IDX_W = 1;
    localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/vxe_biu_arb2_if.sv
// vxe_biu_arb2_if: request/response FIFO port bundle, used for both clients and the BIU.
// The requester side is the master; CW is the CID width on that link.
interface vxe_biu_arb2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CW = 8
);
    logic [CW-1:0] awcid, bcid, arcid, rcid;
    logic [ADDR_WIDTH-1:0] awaddr, araddr;
    logic [DATA_WIDTH-1:0] awdata, rdata;
    logic [DATA_WIDTH/8-1:0] awstrb;
    logic [1:0] bresp, rresp;
    logic awvalid, awpop, bpush, bready, arvalid, arpop, rpush, rready;
    modport master (
        output awcid, awaddr, awdata, awstrb, awvalid, bready, arcid, araddr, arvalid, rready,
        input awpop, bcid, bresp, bpush, arpop, rcid, rdata, rresp, rpush
    );
    modport slave (
        input awcid, awaddr, awdata, awstrb, awvalid, bready, arcid, araddr, arvalid, rready,
        output awpop, bcid, bresp, bpush, arpop, rcid, rdata, rresp, rpush
    );
endinterface

// File: rtl/vxe_biu_arb_chan.sv
// vxe_biu_arb_chan: round-robin two-way request selector with grant lock for one channel.
// Under VXE_BIU_ARB_OUTST_LIMIT_EN it also tracks per-client outstanding requests.
module vxe_biu_arb_chan #(
    parameter int PW = 8
`ifdef VXE_BIU_ARB_OUTST_LIMIT_EN
    , parameter int MAX_OUTST = 4
`endif
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [1:0]    valid,
    input  logic [PW-1:0] pl0,
    input  logic [PW-1:0] pl1,
    input  logic          pop_in,
`ifdef VXE_BIU_ARB_OUTST_LIMIT_EN
    input  logic [1:0]    push,
`endif
    output logic          ovalid,
    output logic          sel,
    output logic [PW-1:0] opl,
    output logic [1:0]    pop
);
    logic lock, gnt, rr;
    logic [1:0] elig;
`ifdef VXE_BIU_ARB_OUTST_LIMIT_EN
    localparam int CNTW = $clog2(MAX_OUTST + 1);
    logic [CNTW-1:0] cnt [2];
    assign elig = valid & {cnt[1] != CNTW'(MAX_OUTST), cnt[0] != CNTW'(MAX_OUTST)};
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) cnt[i] <= cnt[i] + CNTW'(pop[i]) - CNTW'(push[i]);
        end
`else
    assign elig = valid;
`endif
    // A held lock keeps the presented request stable until the BIU consumes it.
    always_comb begin
        sel = lock ? gnt : (&elig ? rr : elig[1]);
        ovalid = lock | (|elig);
        opl = sel ? pl1 : pl0;
        pop = {pop_in & ovalid & sel, pop_in & ovalid & ~sel};
    end
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            lock <= 1'b0;
            gnt <= 1'b0;
            rr <= 1'b0;
        end else begin
            if (ovalid & ~pop_in) begin
                lock <= 1'b1;
                gnt <= sel;
            end else if (pop_in) lock <= 1'b0;
            if (pop_in & ovalid) rr <= ~sel;
        end
endmodule

// File: rtl/vxe_biu_arb2.sv
// vxe_biu_arb2: shares one BIU between two clients; aw/ar arbitrated independently,
// responses routed by the client index tag in the CID MSB. Option: VXE_BIU_ARB_OUTST_LIMIT_EN.
module vxe_biu_arb2
    import vxe_biu_arb2_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CID_WIDTH = 8,
    parameter int MAX_OUTST = 4
) (
    input logic clk,
    input logic nrst,
    vxe_biu_arb2_if.slave m0,
    vxe_biu_arb2_if.slave m1,
    vxe_biu_arb2_if.master biu
);
    localparam int AWP = CID_WIDTH + ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH / 8;
    localparam int ARP = CID_WIDTH + ADDR_WIDTH;
    if (MAX_OUTST < 1) begin : g_bad_outst
        $error("MAX_OUTST must be at least 1");
    end
    logic [IDX_W-1:0] aw_sel, ar_sel;
    logic [AWP-1:0] aw_pl;
    logic [ARP-1:0] ar_pl;
    logic [1:0] aw_pop, ar_pop;
    logic bk, rk;
    vxe_biu_arb_chan #(
        .PW(AWP)
`ifdef VXE_BIU_ARB_OUTST_LIMIT_EN
        , .MAX_OUTST(MAX_OUTST)
`endif
    ) u_aw (
        .clk(clk), .nrst(nrst),
        .valid({m1.awvalid, m0.awvalid}),
        .pl0({m0.awcid, m0.awaddr, m0.awdata, m0.awstrb}),
        .pl1({m1.awcid, m1.awaddr, m1.awdata, m1.awstrb}),
        .pop_in(biu.awpop),
`ifdef VXE_BIU_ARB_OUTST_LIMIT_EN
        .push({m1.bpush, m0.bpush}),
`endif
        .ovalid(biu.awvalid), .sel(aw_sel), .opl(aw_pl), .pop(aw_pop)
    );
    vxe_biu_arb_chan #(
        .PW(ARP)
`ifdef VXE_BIU_ARB_OUTST_LIMIT_EN
        , .MAX_OUTST(MAX_OUTST)
`endif
    ) u_ar (
        .clk(clk), .nrst(nrst),
        .valid({m1.arvalid, m0.arvalid}),
        .pl0({m0.arcid, m0.araddr}),
        .pl1({m1.arcid, m1.araddr}),
        .pop_in(biu.arpop),
`ifdef VXE_BIU_ARB_OUTST_LIMIT_EN
        .push({m1.rpush, m0.rpush}),
`endif
        .ovalid(biu.arvalid), .sel(ar_sel), .opl(ar_pl), .pop(ar_pop)
    );
    assign {biu.awcid, biu.awaddr, biu.awdata, biu.awstrb} = {aw_sel, aw_pl};
    assign {biu.arcid, biu.araddr} = {ar_sel, ar_pl};
    assign {m1.awpop, m0.awpop} = aw_pop;
    assign {m1.arpop, m0.arpop} = ar_pop;
    // Stateless routing: the owning client's ready alone gates the BIU response path.
    assign bk = biu.bcid[CID_WIDTH];
    assign rk = biu.rcid[CID_WIDTH];
    assign biu.bready = bk ? m1.bready : m0.bready;
    assign biu.rready = rk ? m1.rready : m0.rready;
    assign m0.bpush = biu.bpush & ~bk & m0.bready;
    assign m1.bpush = biu.bpush & bk & m1.bready;
    assign m0.rpush = biu.rpush & ~rk & m0.rready;
    assign m1.rpush = biu.rpush & rk & m1.rready;
    assign m0.bcid = biu.bcid[CID_WIDTH-1:0];
    assign m1.bcid = biu.bcid[CID_WIDTH-1:0];
    assign m0.rcid = biu.rcid[CID_WIDTH-1:0];
    assign m1.rcid = biu.rcid[CID_WIDTH-1:0];
    assign m0.bresp = biu.bresp;
    assign m1.bresp = biu.bresp;
    assign m0.rresp = biu.rresp;
    assign m1.rresp = biu.rresp;
    assign m0.rdata = biu.rdata;
    assign m1.rdata = biu.rdata;
endmodule
